// File: rtl/kb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : kb_pkg
// Description : Shared scan-code constants and state encodings for the PS/2
//               keyboard path (frame receiver and scan-code decoder).
// Revision    : 1.0 - initial release
// ============================================================================
package kb_pkg;

    localparam logic [7:0] SC_BREAK  = 8'hF0;
    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_LARROW = 8'h6B;
    localparam logic [7:0] SC_RARROW = 8'h74;

    typedef enum logic [1:0] {
        FR_IDLE   = 2'd0,
        FR_DATA   = 2'd1,
        FR_PARITY = 2'd2,
        FR_STOP   = 2'd3
    } frame_state_t;

    typedef enum logic [1:0] {
        DEC_BASE  = 2'd0,
        DEC_PF0   = 2'd1,
        DEC_PE0   = 2'd2,
        DEC_PE0F0 = 2'd3
    } dec_state_t;

endpackage
`default_nettype wire

// File: rtl/ps2_rx_frame.sv
`default_nettype none
// ============================================================================
// Module      : ps2_rx_frame
// Description : Synchronises the raw PS/2 clock/data, samples data on each
//               falling PS/2 clock edge and deframes 11-bit frames. Emits a
//               byte_valid pulse for good frames and a frame_err pulse on
//               parity, stop-bit or watchdog failure.
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_rx_frame
    import kb_pkg::*;
#(
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_ps_clk,
    input  logic       i_ps_data,
    output logic       o_byte_valid,
    output logic [7:0] o_byte,
    output logic       o_frame_err
);

    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [WD_W-1:0] C_WD_MAX = WD_W'(TIMEOUT_CYC);

    logic            r_clk_s1, r_clk_s2, r_clk_hist;
    logic            r_dat_s1, r_dat_s2;
    logic            w_fall;
    logic            w_timeout;
    frame_state_t    r_state, w_state_nx;
    logic [2:0]      r_bit_cnt;
    logic [7:0]      r_shift;
    logic            r_par;
    logic [WD_W-1:0] r_wdog;

    // Two-stage synchronisers plus a history stage on the PS/2 clock; the
    // lines idle high, so reset them high to avoid a false edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_clk_s1   <= 1'b1;
            r_clk_s2   <= 1'b1;
            r_clk_hist <= 1'b1;
            r_dat_s1   <= 1'b1;
            r_dat_s2   <= 1'b1;
        end else begin
            r_clk_s1   <= i_ps_clk;
            r_clk_s2   <= r_clk_s1;
            r_clk_hist <= r_clk_s2;
            r_dat_s1   <= i_ps_data;
            r_dat_s2   <= r_dat_s1;
        end
    end

    assign w_fall    = r_clk_hist & ~r_clk_s2;
    assign w_timeout = (r_state != FR_IDLE) && (r_wdog == C_WD_MAX);
    assign o_byte    = r_shift;

    // Frame state register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= FR_IDLE;
        else     r_state <= w_state_nx;
    end

    // Frame sequencing and the good/bad verdict on the stop-bit edge.
    always_comb begin
        w_state_nx   = r_state;
        o_byte_valid = 1'b0;
        o_frame_err  = 1'b0;
        if (w_fall) begin
            case (r_state)
                FR_IDLE:   if (!r_dat_s2) w_state_nx = FR_DATA;
                FR_DATA:   if (r_bit_cnt == 3'd7) w_state_nx = FR_PARITY;
                FR_PARITY: w_state_nx = FR_STOP;
                FR_STOP: begin
                    w_state_nx = FR_IDLE;
                    // Odd parity: data plus parity bit must hold an odd number of ones.
                    if (r_dat_s2 && (^{r_shift, r_par})) o_byte_valid = 1'b1;
                    else                                 o_frame_err  = 1'b1;
                end
                default:   w_state_nx = FR_IDLE;
            endcase
        end else if (w_timeout) begin
            w_state_nx  = FR_IDLE;
            o_frame_err = 1'b1;
        end
    end

    // Deserialiser, parity capture and saturating inactivity watchdog.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bit_cnt <= 3'd0;
            r_shift   <= 8'd0;
            r_par     <= 1'b0;
            r_wdog    <= '0;
        end else begin
            if (r_state == FR_IDLE) r_bit_cnt <= 3'd0;
            if (w_fall) begin
                r_wdog <= '0;
                if (r_state == FR_DATA) begin
                    r_shift   <= {r_dat_s2, r_shift[7:1]};
                    r_bit_cnt <= r_bit_cnt + 3'd1;
                end
                if (r_state == FR_PARITY) r_par <= r_dat_s2;
            end else if (r_state == FR_IDLE) begin
                r_wdog <= '0;
            end else if (r_wdog != C_WD_MAX) begin
                r_wdog <= r_wdog + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/ps2_key_tracker.sv
`default_nettype none
// ============================================================================
// Module      : ps2_key_tracker
// Description : PS/2 keyboard front end for the game. Sequences E0/F0
//               prefixes into complete scan codes, tracks held left/right/
//               fire keys and produces the movement vector and a one-shot
//               fire request.
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_key_tracker
    import kb_pkg::*;
#(
    parameter int         TIMEOUT_CYC = 50000,
    parameter logic [7:0] KEY_LEFT    = 8'h1C,
    parameter logic [7:0] KEY_RIGHT   = 8'h23,
    parameter logic [7:0] KEY_FIRE    = 8'h29
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps_clk,
    input  logic       ps_data,
    output logic [1:0] user_move,
    output logic       fire,
    output logic       key_valid,
    output logic [7:0] key_code,
    output logic       key_break,
    output logic       key_ext,
    output logic       frame_err
);

    logic       w_byte_valid;
    logic [7:0] w_byte;
    logic       w_rx_err;
    dec_state_t r_dec, w_dec_nx;
    logic       w_emit, w_junk, w_brk, w_ext;
    logic       w_is_left, w_is_right, w_is_fire;
    logic       w_left_nx, w_right_nx, w_fire_nx, w_fire_pulse;
    logic       r_left_held, r_right_held, r_fire_held;

    ps2_rx_frame #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_rx (
        .clk          (clk),
        .rst          (reset),
        .i_ps_clk     (ps_clk),
        .i_ps_data    (ps_data),
        .o_byte_valid (w_byte_valid),
        .o_byte       (w_byte),
        .o_frame_err  (w_rx_err)
    );

    // Prefix state register.
    always_ff @(posedge clk) begin
        if (reset) r_dec <= DEC_BASE;
        else       r_dec <= w_dec_nx;
    end

    // Prefix sequencing: prefixes only move state, any other byte completes a code.
    always_comb begin
        w_dec_nx = r_dec;
        w_emit   = 1'b0;
        w_junk   = 1'b0;
        w_brk    = 1'b0;
        w_ext    = 1'b0;
        if (w_byte_valid) begin
            case (r_dec)
                DEC_BASE: begin
                    if (w_byte == SC_BREAK)    w_dec_nx = DEC_PF0;
                    else if (w_byte == SC_EXT) w_dec_nx = DEC_PE0;
                    else                       w_emit   = 1'b1;
                end
                DEC_PE0: begin
                    w_ext = 1'b1;
                    if (w_byte == SC_BREAK) begin
                        w_dec_nx = DEC_PE0F0;
                    end else begin
                        w_dec_nx = DEC_BASE;
                        if (w_byte == SC_EXT) w_junk = 1'b1;
                        else                  w_emit = 1'b1;
                    end
                end
                DEC_PF0, DEC_PE0F0: begin
                    w_brk    = 1'b1;
                    w_ext    = (r_dec == DEC_PE0F0);
                    w_dec_nx = DEC_BASE;
                    if ((w_byte == SC_BREAK) || (w_byte == SC_EXT)) w_junk = 1'b1;
                    else                                            w_emit = 1'b1;
                end
                default: w_dec_nx = DEC_BASE;
            endcase
        end
    end

    // Map the completed code onto the tracked keys and derive next held state.
    always_comb begin
        w_is_left  = ((w_byte == KEY_LEFT)  && !w_ext) || ((w_byte == SC_LARROW) && w_ext);
        w_is_right = ((w_byte == KEY_RIGHT) && !w_ext) || ((w_byte == SC_RARROW) && w_ext);
        w_is_fire  =  (w_byte == KEY_FIRE)  && !w_ext;
        w_left_nx  = r_left_held;
        w_right_nx = r_right_held;
        w_fire_nx  = r_fire_held;
        if (w_emit && w_is_left)  w_left_nx  = ~w_brk;
        if (w_emit && w_is_right) w_right_nx = ~w_brk;
        if (w_emit && w_is_fire)  w_fire_nx  = ~w_brk;
        // Typematic repeats arrive while fire is already held and must not re-fire.
        w_fire_pulse = w_emit && w_is_fire && !w_brk && !r_fire_held;
    end

    // Registered outputs and held-key flags, all updated alongside key_valid.
    always_ff @(posedge clk) begin
        if (reset) begin
            key_valid    <= 1'b0;
            key_code     <= 8'd0;
            key_break    <= 1'b0;
            key_ext      <= 1'b0;
            fire         <= 1'b0;
            frame_err    <= 1'b0;
            user_move    <= 2'b00;
            r_left_held  <= 1'b0;
            r_right_held <= 1'b0;
            r_fire_held  <= 1'b0;
        end else begin
            key_valid    <= w_emit;
            fire         <= w_fire_pulse;
            frame_err    <= w_rx_err | w_junk;
            r_left_held  <= w_left_nx;
            r_right_held <= w_right_nx;
            r_fire_held  <= w_fire_nx;
            user_move    <= {w_left_nx & ~w_right_nx, w_right_nx & ~w_left_nx};
            if (w_emit) begin
                key_code  <= w_byte;
                key_break <= w_brk;
                key_ext   <= w_ext;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ps2_key_tracker.sv
`default_nettype none
// ============================================================================
// Module      : tb_ps2_key_tracker
// Description : Self-checking bench for ps2_key_tracker: directed key
//               sequences, error frames and randomised key events checked
//               against a key-event level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_key_tracker;

    localparam int TO   = 200;
    localparam int HALF = 15;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ps_clk = 1'b1;
    logic       ps_data = 1'b1;
    logic [1:0] user_move;
    logic       fire, key_valid, key_break, key_ext, frame_err;
    logic [7:0] key_code;

    int n_checks = 0;
    int n_pass   = 0;
    int kv_cnt   = 0;
    int err_cnt  = 0;
    int fire_cnt = 0;

    // Reference model: which tracked keys are currently held.
    bit m_l = 1'b0, m_r = 1'b0, m_f = 1'b0;

    ps2_key_tracker #(
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .ps_clk    (ps_clk),
        .ps_data   (ps_data),
        .user_move (user_move),
        .fire      (fire),
        .key_valid (key_valid),
        .key_code  (key_code),
        .key_break (key_break),
        .key_ext   (key_ext),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    // Count output pulses away from the active edge.
    always @(negedge clk) begin
        if (key_valid) kv_cnt   <= kv_cnt + 1;
        if (frame_err) err_cnt  <= err_cnt + 1;
        if (fire)      fire_cnt <= fire_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic send_bits(input logic [7:0] b, input bit bad_par, input int nbits);
        logic [10:0] f;
        f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps_data = f[i];
            repeat (HALF) @(posedge clk);
            #1 ps_clk = 1'b0;
            repeat (HALF) @(posedge clk);
            #1 ps_clk = 1'b1;
        end
        ps_data = 1'b1;
    endtask

    task automatic settle();
        repeat (10) @(posedge clk);
        #1;
    endtask

    task automatic send_prefix(input logic [7:0] b, input string tag);
        int kv0, er0;
        kv0 = kv_cnt;
        er0 = err_cnt;
        send_bits(b, 1'b0, 11);
        settle();
        chk({tag, "_no_kv"},  kv_cnt - kv0,  0);
        chk({tag, "_no_err"}, err_cnt - er0, 0);
    endtask

    // One complete key event: optional E0, optional F0, then the code byte.
    task automatic do_event(input logic [7:0] code, input bit ext, input bit brk);
        int  kv0, er0, fi0;
        bit  is_l, is_r, is_f, exp_fire;
        if (ext) send_prefix(8'hE0, "pre_e0");
        if (brk) send_prefix(8'hF0, "pre_f0");
        kv0 = kv_cnt;
        er0 = err_cnt;
        fi0 = fire_cnt;
        send_bits(code, 1'b0, 11);
        settle();
        is_l = ext ? (code == 8'h6B) : (code == 8'h1C);
        is_r = ext ? (code == 8'h74) : (code == 8'h23);
        is_f = !ext && (code == 8'h29);
        exp_fire = is_f && !brk && !m_f;
        if (is_l) m_l = !brk;
        if (is_r) m_r = !brk;
        if (is_f) m_f = !brk;
        chk("kv_pulse",  kv_cnt - kv0,   1);
        chk("no_err",    err_cnt - er0,  0);
        chk("key_code",  key_code,       code);
        chk("key_break", key_break,      brk);
        chk("key_ext",   key_ext,        ext);
        chk("user_move", user_move,      {m_l && !m_r, m_r && !m_l});
        chk("fire",      fire_cnt - fi0, exp_fire);
    endtask

    initial begin
        int kv0, er0;
        logic [7:0] tbl [8];
        logic [7:0] code;
        bit ext, brk;
        tbl = '{8'h1C, 8'h23, 8'h29, 8'h6B, 8'h74, 8'h15, 8'h5A, 8'h12};

        repeat (5) @(posedge clk);
        #1;
        chk("reset_outs", {user_move, fire, key_valid, key_code, key_break, key_ext, frame_err}, 0);
        reset = 1'b0;
        repeat (5) @(posedge clk);

        // Left make/break, arrow + D combinations.
        do_event(8'h1C, 1'b0, 1'b0);
        do_event(8'h1C, 1'b0, 1'b1);
        do_event(8'h74, 1'b1, 1'b0);
        do_event(8'h23, 1'b0, 1'b0);
        do_event(8'h74, 1'b1, 1'b1);

        // Fire: typematic repeats fire once; break then make fires again.
        do_event(8'h29, 1'b0, 1'b0);
        do_event(8'h29, 1'b0, 1'b0);
        do_event(8'h29, 1'b0, 1'b0);
        do_event(8'h29, 1'b0, 1'b1);
        do_event(8'h29, 1'b0, 1'b0);

        // Bad parity: dropped with an error, movement unchanged.
        kv0 = kv_cnt; er0 = err_cnt;
        send_bits(8'h1C, 1'b1, 11);
        settle();
        chk("par_err",  err_cnt - er0, 1);
        chk("par_nokv", kv_cnt - kv0,  0);
        chk("par_move", user_move, {m_l && !m_r, m_r && !m_l});
        do_event(8'h1C, 1'b0, 1'b0);

        // Protocol junk: E0 followed by E0.
        send_prefix(8'hE0, "junk_first");
        kv0 = kv_cnt; er0 = err_cnt;
        send_bits(8'hE0, 1'b0, 11);
        settle();
        chk("junk_err",  err_cnt - er0, 1);
        chk("junk_nokv", kv_cnt - kv0,  0);
        do_event(8'h6B, 1'b1, 1'b1);

        // Watchdog: frame stalls after five data bits.
        kv0 = kv_cnt; er0 = err_cnt;
        send_bits(8'h1C, 1'b0, 6);
        repeat (TO + 30) @(posedge clk);
        #1;
        chk("to_err",  err_cnt - er0, 1);
        chk("to_nokv", kv_cnt - kv0,  0);
        do_event(8'h23, 1'b0, 1'b1);

        // Randomised key events.
        for (int n = 0; n < 30; n++) begin
            code = tbl[$urandom_range(0, 7)];
            if (code == 8'h6B || code == 8'h74) ext = ($urandom_range(0, 3) != 0);
            else                                ext = ($urandom_range(0, 3) == 0);
            brk = 1'($urandom_range(0, 1));
            do_event(code, ext, brk);
        end

        // Reset in the middle of a frame.
        send_bits(8'h23, 1'b0, 4);
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("midrst_outs", {user_move, fire, key_valid, key_code, key_break, key_ext, frame_err}, 0);
        m_l = 1'b0; m_r = 1'b0; m_f = 1'b0;
        ps_clk = 1'b1;
        ps_data = 1'b1;
        reset = 1'b0;
        repeat (5) @(posedge clk);
        do_event(8'h23, 1'b0, 1'b0);
        chk("midrst_move", user_move, 2'b01);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
